// File: rtl/bcd_mod_counter.sv
// Up/down BCD counter with programmable modulus, synchronous preset, combinational TC for cascading.
// Cnt/CO/ERR update one CP edge after inputs; TC is same-cycle; no backpressure (EN hold only).
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                CP,
  input  logic                nCR,
  input  logic                EN,
  input  logic                UP,
  input  logic                LD,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Cnt,
  output logic                TC,
  output logic                CO,
  output logic                ERR
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  generate
    if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_params
      $error("bcd_mod_counter: illegal DIGITS/MODULUS combination");
    end
  endgenerate

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] cnt_inc;
  logic [W-1:0] cnt_dec;
  logic         carry;
  logic         borrow;
  logic         d_bcd_ok;
  logic         d_legal;
  logic         at_max;
  logic         at_zero;

  // Digit-serial carry/borrow ripple; digits past the first non-rolling one pass through.
  always_comb begin
    cnt_inc  = Cnt;
    cnt_dec  = Cnt;
    carry    = 1'b1;
    borrow   = 1'b1;
    d_bcd_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (Cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = Cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (Cnt[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = Cnt[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
      if (D[4*i +: 4] > 4'd9) d_bcd_ok = 1'b0;
    end
  end

  // With every digit valid, BCD order matches plain unsigned order.
  assign d_legal = d_bcd_ok && (D <= MAX_BCD);
  assign at_max  = (Cnt == MAX_BCD);
  assign at_zero = (Cnt == '0);

  assign TC = nCR & EN & ~LD & ((UP & at_max) | (~UP & at_zero));

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      Cnt <= '0;
      CO  <= 1'b0;
      ERR <= 1'b0;
    end else if (LD) begin
      CO <= 1'b0;
      if (d_legal) begin
        Cnt <= D;
        ERR <= 1'b0;
      end else begin
        Cnt <= '0;
        ERR <= 1'b1;
      end
    end else if (EN) begin
      if (UP) begin
        Cnt <= at_max ? '0 : cnt_inc;
        CO  <= at_max;
      end else begin
        Cnt <= at_zero ? MAX_BCD : cnt_dec;
        CO  <= at_zero;
      end
    end else begin
      CO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: mod-60, mod-24, mod-10 and a seconds/minutes cascade.
module tb_bcd_mod_counter;

  logic CP;
  logic nCR;

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // mod-60, 2 digits
  logic       en, up, ld;
  logic [7:0] d, cnt;
  logic       tc, co, err;
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u60 (
    .CP(CP), .nCR(nCR), .EN(en), .UP(up), .LD(ld), .D(d),
    .Cnt(cnt), .TC(tc), .CO(co), .ERR(err));

  // mod-24, 2 digits
  logic       en24, up24, ld24;
  logic [7:0] d24, cnt24;
  logic       tc24, co24, err24;
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u24 (
    .CP(CP), .nCR(nCR), .EN(en24), .UP(up24), .LD(ld24), .D(d24),
    .Cnt(cnt24), .TC(tc24), .CO(co24), .ERR(err24));

  // mod-10, 1 digit
  logic       en10, up10, ld10;
  logic [3:0] d10, cnt10;
  logic       tc10, co10, err10;
  bcd_mod_counter #(.DIGITS(1), .MODULUS(10)) u10 (
    .CP(CP), .nCR(nCR), .EN(en10), .UP(up10), .LD(ld10), .D(d10),
    .Cnt(cnt10), .TC(tc10), .CO(co10), .ERR(err10));

  // seconds -> minutes cascade
  logic       cas_en, cas_ld;
  logic [7:0] sec_d, min_d, sec_cnt, min_cnt;
  logic       sec_tc, sec_co, sec_err, min_tc, min_co, min_err;
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (
    .CP(CP), .nCR(nCR), .EN(cas_en), .UP(1'b1), .LD(cas_ld), .D(sec_d),
    .Cnt(sec_cnt), .TC(sec_tc), .CO(sec_co), .ERR(sec_err));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (
    .CP(CP), .nCR(nCR), .EN(sec_tc), .UP(1'b1), .LD(cas_ld), .D(min_d),
    .Cnt(min_cnt), .TC(min_tc), .CO(min_co), .ERR(min_err));

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  function automatic logic [7:0] b2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    int e;
    checks = 0;
    errors = 0;
    nCR = 1'b0;
    en = 1'b1; up = 1'b0; ld = 1'b0; d = 8'h00;
    en24 = 1'b0; up24 = 1'b1; ld24 = 1'b0; d24 = 8'h00;
    en10 = 1'b0; up10 = 1'b1; ld10 = 1'b0; d10 = 4'h0;
    cas_en = 1'b0; cas_ld = 1'b0; sec_d = 8'h00; min_d = 8'h00;

    // reset state; TC must stay low even though EN=1, UP=0, Cnt=0
    #12;
    check("rst_cnt", cnt, 8'h00);
    check("rst_co", co, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tc", tc, 1'b0);
    #5 nCR = 1'b1;

    // count up through a full mod-60 cycle
    en = 1'b1; up = 1'b1;
    #1;
    e = 0;
    for (int k = 0; k < 60; k++) begin
      check("up_tc", tc, (e == 59));
      step();
      e = (e + 1) % 60;
      check("up_cnt", cnt, b2(e));
      check("up_co", co, (e == 0));
    end
    check("up_end", cnt, 8'h00);

    // down count wraps 00 -> 59
    up = 1'b0;
    #1 check("dn_tc_zero", tc, 1'b1);
    step();
    check("dn_wrap_cnt", cnt, 8'h59);
    check("dn_wrap_co", co, 1'b1);
    step();
    check("dn_cnt58", cnt, 8'h58);
    check("dn_co58", co, 1'b0);

    // hold
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_cnt", cnt, 8'h58);
      check("hold_tc", tc, 1'b0);
      check("hold_co", co, 1'b0);
    end

    // digit borrow 10 -> 09
    ld = 1'b1; d = 8'h10;
    step();
    check("ld10", cnt, 8'h10);
    ld = 1'b0; en = 1'b1; up = 1'b0;
    step();
    check("borrow", cnt, 8'h09);

    // loads, legal and illegal
    en = 1'b0; ld = 1'b1; d = 8'h45;
    step();
    check("ld45_cnt", cnt, 8'h45);
    check("ld45_err", err, 1'b0);
    d = 8'h7A;
    step();
    check("ld7A_cnt", cnt, 8'h00);
    check("ld7A_err", err, 1'b1);
    d = 8'h60;
    step();
    check("ld60_cnt", cnt, 8'h00);
    check("ld60_err", err, 1'b1);
    ld = 1'b0;
    step();
    check("err_hold", err, 1'b1);
    ld = 1'b1; d = 8'h12;
    step();
    check("ld12_cnt", cnt, 8'h12);
    check("ld12_err", err, 1'b0);

    // load beats count and masks TC
    d = 8'h59;
    step();
    en = 1'b1; up = 1'b1; d = 8'h30;
    #1 check("ld_tc_mask", tc, 1'b0);
    step();
    check("ld_wins_cnt", cnt, 8'h30);
    check("ld_wins_co", co, 1'b0);
    ld = 1'b0; en = 1'b0;

    // mod-24
    ld24 = 1'b1; d24 = 8'h22;
    step();
    ld24 = 1'b0; en24 = 1'b1; up24 = 1'b1;
    step();
    check("m24_23", cnt24, 8'h23);
    check("m24_tc", tc24, 1'b1);
    step();
    check("m24_wrap", cnt24, 8'h00);
    check("m24_co", co24, 1'b1);
    up24 = 1'b0;
    step();
    check("m24_dn", cnt24, 8'h23);
    check("m24_dn_co", co24, 1'b1);
    en24 = 1'b0;

    // mod-10, single digit
    ld10 = 1'b1; d10 = 4'h9;
    step();
    ld10 = 1'b0; en10 = 1'b1; up10 = 1'b1;
    #1 check("m10_tc", tc10, 1'b1);
    step();
    check("m10_wrap", cnt10, 4'h0);
    check("m10_co", co10, 1'b1);
    step();
    check("m10_1", cnt10, 4'h1);
    check("m10_co_low", co10, 1'b0);
    en10 = 1'b0;

    // cascade 00:58 -> 00:59 -> 01:00 -> 01:01
    cas_ld = 1'b1; sec_d = 8'h58; min_d = 8'h00;
    step();
    cas_ld = 1'b0; cas_en = 1'b1;
    step();
    check("cas1_sec", sec_cnt, 8'h59);
    check("cas1_min", min_cnt, 8'h00);
    check("cas1_tc", sec_tc, 1'b1);
    step();
    check("cas2_sec", sec_cnt, 8'h00);
    check("cas2_min", min_cnt, 8'h01);
    step();
    check("cas3_sec", sec_cnt, 8'h01);
    check("cas3_min", min_cnt, 8'h01);
    cas_en = 1'b0;

    // async reset mid-operation at 37 with ERR set
    ld = 1'b1; d = 8'hFF;
    step();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 37; k++) step();
    check("pre_rst_cnt", cnt, 8'h37);
    check("pre_rst_err", err, 1'b1);
    #2 nCR = 1'b0;
    #1;
    check("arst_cnt", cnt, 8'h00);
    check("arst_co", co, 1'b0);
    check("arst_err", err, 1'b0);
    #2 nCR = 1'b1;
    step();
    check("post_rst", cnt, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised synchronous BCD counter with a programmable modulus and digit count, for the clock/calendar time-keeping chain.
- Counts up or down, supports a synchronous preset, and produces a combinational terminal-count output for cascading.
- Produces a registered wrap pulse and a sticky error flag.
- Replaces the fixed mod-60 and mod-10/mod-6 counters; one instance covers seconds/minutes (60), hours (24 or 12) and day-of-month-style ranges.

Parameters:
- DIGITS, 2: number of BCD digits; Cnt width is 4*DIGITS. Legal range 1..4.
- MODULUS, 60: count range is 0..MODULUS-1. Legal range 2..10^DIGITS. Elaboration fails for an illegal value.

Ports:
- CP, input, 1: clock; all state changes on the rising edge.
- nCR, input, 1: asynchronous active-low reset (clear).
- EN, input, 1: count enable; 0 = hold.
- UP, input, 1: direction; 1 = increment, 0 = decrement.
- LD, input, 1: synchronous load strobe.
- D, input, 4*DIGITS: BCD preset value.
- Cnt, output, 4*DIGITS: current count, 8421 BCD, digit 0 in [3:0].
- TC, output, 1: terminal count, combinational.
- CO, output, 1: registered one-cycle wrap pulse.
- ERR, output, 1: sticky illegal-load flag.

Behaviour:
- Reset: when nCR=0, asynchronously Cnt=0, CO=0, ERR=0. This overrides all other inputs. Counting resumes on the first CP edge after nCR returns to 1.
- Per-edge priority (nCR=1): LD > EN > hold.
- LD=1 with D legal (every digit 0..9 and value < MODULUS): Cnt<=D, ERR<=0, CO<=0. LD acts regardless of EN and UP.
- LD=1 with D illegal (any digit > 9, or value >= MODULUS): Cnt<=0, ERR<=1, CO<=0.
- LD=0, EN=0: Cnt holds, CO<=0, ERR holds.
- LD=0, EN=1, UP=1:
  - If Cnt == MODULUS-1: Cnt<=0, CO<=1.
  - Otherwise: Cnt<=Cnt+1 in BCD, CO<=0. A digit at 9 rolls to 0 and increments the next digit.
- LD=0, EN=1, UP=0:
  - If Cnt == 0: Cnt<=MODULUS-1 (BCD encoded), CO<=1.
  - Otherwise: Cnt<=Cnt-1 in BCD, CO<=0. A digit at 0 rolls to 9 and decrements the next digit.
- BCD arithmetic:
  - Implemented per digit with digit-carry/borrow chaining; no binary adder followed by conversion.
  - Cnt never holds a non-BCD digit or a value >= MODULUS.
- Terminal count:
  - TC = EN & ~LD & ((UP & Cnt==MODULUS-1) | (~UP & Cnt==0)).
  - TC is combinational and same-cycle. It drives the EN of the next cascaded stage sharing CP.
  - TC is 0 during reset.
- CO is high for exactly one cycle after each wrap edge. Consecutive wraps (e.g. MODULUS=2, EN held high) give CO high on every wrap cycle.
- Direction change takes effect on the next edge. No extra latency, no state kept about the previous direction.
- MODULUS constants (MODULUS-1 in BCD) are computed at elaboration. No runtime multiply or divide.
- Latency:
  - Cnt, CO and ERR update one CP edge after the qualifying inputs.
  - TC has zero latency.
- ERR changes only three ways: set by an illegal load, cleared by a legal load, cleared by nCR.

Test Plan:
- Reset and count up: nCR=0 pulse, then EN=1, UP=1 for 60 edges, DIGITS=2, MODULUS=60 -> Cnt steps 00,01,…,09,10,…,59,00. TC=1 only while Cnt=59. CO=1 only in the cycle Cnt=00 after the wrap.
- Down count and hold: from Cnt=00 with UP=0, EN=1 -> 59, 58; then EN=0 for 3 edges -> Cnt stays 58, TC=0. At Cnt=10, one edge -> 09 (digit borrow).
- Load legal and illegal: LD=1, D=8'h45 with EN=0 -> Cnt=45, ERR=0. Then D=8'h7A -> Cnt=00, ERR=1. Then D=8'h60 -> Cnt=00, ERR=1. Then D=8'h12 -> Cnt=12, ERR=0. With LD=1 and EN=1 together -> the load wins.
- Alternate modulus, MODULUS=24: count up from 22 -> 23, 00 with CO pulse. Count down from 00 -> 23. Also instance DIGITS=1, MODULUS=10: 9 -> 0 wraps with CO.
- Cascade: seconds instance (60) TC drives EN of minutes instance (60). Start 00:58, EN=1 -> 00:59, 01:00, 01:01. The minutes stage increments only on the edge where seconds=59.
- Async reset mid-operation: assert nCR between CP edges at Cnt=37 with ERR=1 -> Cnt=00, CO=0, ERR=0 immediately, without waiting for a clock edge. The first edge after release with EN=1, UP=1 -> Cnt=01.
